// File: rtl/bounce_gen_pkg.sv
// Shared definitions for the button-bounce emulator: FSM encoding, LFSR taps, default seed.
package bounce_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS_B = 3'd1,
    ST_HOLD    = 3'd2,
    ST_REL_B   = 3'd3,
    ST_SETTLE  = 3'd4
  } state_t;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads the seed on synchronous active-low reset.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// Mechanical button emulator: bouncy press, stable hold, bouncy release, quiet settle.
// Optional BOUNCE_GEN_RISE_CNT_EN adds an 8-bit wrapping count of btn_out rising edges.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int          BOUNCE_EDGES  = 6,
  parameter int          GAP_W         = 4,
  parameter int          HOLD_CYCLES   = 200,
  parameter int          SETTLE_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       press_req,
  output logic       btn_out,
  output logic       busy,
  output logic       done
`ifdef BOUNCE_GEN_RISE_CNT_EN
  ,
  output logic [7:0] rise_count
`endif
);

  localparam int GAP_CW    = GAP_W + 1;
  localparam int EDGE_W    = (BOUNCE_EDGES < 1) ? 1 : $clog2(BOUNCE_EDGES + 1);
  localparam int HOLD_W    = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int SETTLE_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [EDGE_W-1:0]   EDGES_L  = EDGE_W'(BOUNCE_EDGES);
  localparam logic [HOLD_W-1:0]   HOLD_L   = HOLD_W'(HOLD_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_L = SETTLE_W'(SETTLE_CYCLES);

  logic [15:0] lfsr_q;
  logic [GAP_CW-1:0] gap;
  logic unused_lfsr_bits;

  state_t              state_d,  state_q;
  logic                btn_d,    btn_q;
  logic                busy_d,   busy_q;
  logic                done_d,   done_q;
  logic [GAP_CW-1:0]   gap_d,    gap_q;
  logic [EDGE_W-1:0]   edge_d,   edge_q;
  logic [HOLD_W-1:0]   hold_d,   hold_q;
  logic [SETTLE_W-1:0] settle_d, settle_q;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Gap of 1..2^GAP_W cycles drawn from the low LFSR bits
  assign gap = {1'b0, lfsr_q[GAP_W-1:0]} + GAP_CW'(1);
  assign unused_lfsr_bits = ^lfsr_q[15:GAP_W];

  always_comb begin
    state_d  = state_q;
    btn_d    = btn_q;
    gap_d    = gap_q;
    edge_d   = edge_q;
    hold_d   = hold_q;
    settle_d = settle_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        btn_d = 1'b0;
        if (press_req) begin
          state_d = ST_PRESS_B;
          gap_d   = gap;
          edge_d  = '0;
        end
      end

      ST_PRESS_B: begin
        if (gap_q == GAP_CW'(1)) begin
          gap_d = gap;
          if (edge_q == EDGES_L) begin
            btn_d   = 1'b1;
            state_d = ST_HOLD;
            hold_d  = HOLD_L;
          end else begin
            btn_d  = ~btn_q;
            edge_d = edge_q + EDGE_W'(1);
          end
        end else begin
          gap_d = gap_q - GAP_CW'(1);
        end
      end

      ST_HOLD: begin
        btn_d = 1'b1;
        if (hold_q == HOLD_W'(1)) begin
          state_d = ST_REL_B;
          gap_d   = gap;
          edge_d  = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      // Release bounce starts from a high level and ends by dropping into SETTLE
      ST_REL_B: begin
        if (gap_q == GAP_CW'(1)) begin
          gap_d = gap;
          if (edge_q == EDGES_L) begin
            btn_d    = 1'b0;
            state_d  = ST_SETTLE;
            settle_d = SETTLE_L;
          end else begin
            btn_d  = ~btn_q;
            edge_d = edge_q + EDGE_W'(1);
          end
        end else begin
          gap_d = gap_q - GAP_CW'(1);
        end
      end

      ST_SETTLE: begin
        btn_d = 1'b0;
        if (settle_q == SETTLE_W'(1)) begin
          state_d = ST_IDLE;
          gap_d   = gap;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - SETTLE_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        btn_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      btn_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gap_q    <= '0;
      edge_q   <= '0;
      hold_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      btn_q    <= btn_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gap_q    <= gap_d;
      edge_q   <= edge_d;
      hold_q   <= hold_d;
      settle_q <= settle_d;
    end
  end

  assign btn_out = btn_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef BOUNCE_GEN_RISE_CNT_EN
  logic [7:0] rise_cnt_d, rise_cnt_q;

  always_comb begin
    rise_cnt_d = rise_cnt_q;
    if (btn_d && !btn_q) begin
      rise_cnt_d = rise_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_cnt_q <= 8'd0;
    end else begin
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign rise_count = rise_cnt_q;
`endif

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: a bouncing instance (4 edges) and a clean-edge instance (0 edges).
module tb_bounce_gen;
  import bounce_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, press_req, btn_out, busy, done;
  logic rst0_n, press0, btn0, busy0, done0;
`ifdef BOUNCE_GEN_RISE_CNT_EN
  logic [7:0] rise_count, rise_count0;
`endif

  bounce_gen #(
    .BOUNCE_EDGES(4), .GAP_W(2), .HOLD_CYCLES(20), .SETTLE_CYCLES(10), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .press_req(press_req),
    .btn_out(btn_out), .busy(busy), .done(done)
`ifdef BOUNCE_GEN_RISE_CNT_EN
    , .rise_count(rise_count)
`endif
  );

  bounce_gen #(
    .BOUNCE_EDGES(0), .GAP_W(2), .HOLD_CYCLES(20), .SETTLE_CYCLES(10), .LFSR_SEED(16'hACE1)
  ) dut0 (
    .clk(clk), .rst_n(rst0_n), .press_req(press0),
    .btn_out(btn0), .busy(busy0), .done(done0)
`ifdef BOUNCE_GEN_RISE_CNT_EN
    , .rise_count(rise_count0)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  int s_press_rises, s_rel_rises, s_falls, s_hold_cyc, s_hold_low;
  int s_done, s_busy_low, s_settle_run, s_max_high;
  bit s_done_busy, s_timeout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collects waveform statistics for one sequence on the selected instance, up to done.
  task automatic observe(input bit sel, input bit poke, input int limit);
    bit prev, b, bz, dn, inhold, hold_seen;
    int low_run, high_run;
    s_press_rises = 0; s_rel_rises = 0; s_falls = 0; s_hold_cyc = 0; s_hold_low = 0;
    s_done = 0; s_busy_low = 0; s_settle_run = 0; s_max_high = 0;
    s_done_busy = 1'b1; s_timeout = 1'b1;
    prev = sel ? btn0 : btn_out;
    hold_seen = 1'b0; low_run = 0; high_run = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      b      = sel ? btn0 : btn_out;
      bz     = sel ? busy0 : busy;
      dn     = sel ? done0 : done;
      inhold = sel ? (dut0.state_q == ST_HOLD) : (dut.state_q == ST_HOLD);
      if (b && !prev) begin
        if (hold_seen) s_rel_rises++;
        else s_press_rises++;
      end
      if (!b && prev) s_falls++;
      if (inhold) begin
        s_hold_cyc++;
        if (!b) s_hold_low++;
        hold_seen = 1'b1;
      end
      if (dn) begin
        s_done++;
        s_settle_run = low_run;
        s_done_busy  = bz;
        s_timeout    = 1'b0;
        break;
      end
      if (!bz) s_busy_low++;
      if (b) begin
        high_run++;
        low_run = 0;
        if (high_run > s_max_high) s_max_high = high_run;
      end else begin
        low_run++;
        high_run = 0;
      end
      prev = b;
      if (poke) press_req = (s_hold_cyc == 10);
    end
    if (poke) press_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst0_n = 1'b0; press_req = 1'b0; press0 = 1'b0;
    tick();
    tick();
    n_tests++;
    if (btn_out !== 1'b0) begin n_fail++; $display("FAIL reset_btn got=%b want=0", btn_out); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_tests++;
    if (dut.u_lfsr.q !== 16'hACE1) begin
      n_fail++; $display("FAIL reset_lfsr got=%h want=ace1", dut.u_lfsr.q);
    end
    n_tests++;
    if ({btn0, busy0, done0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_dut0 got=%b want=000", {btn0, busy0, done0});
    end
`ifdef BOUNCE_GEN_RISE_CNT_EN
    n_tests++;
    if (rise_count !== 8'd0) begin n_fail++; $display("FAIL reset_rise_count got=%0d want=0", rise_count); end
`endif
    rst_n = 1'b1; rst0_n = 1'b1;
    tick();
    n_tests++;
    if (dut.u_lfsr.q !== 16'h59C3) begin
      n_fail++; $display("FAIL lfsr_step got=%h want=59c3", dut.u_lfsr.q);
    end
  endtask

  task automatic test_press();
    press_req = 1'b1;
    tick();
    press_req = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL press_busy got=%b want=1", busy); end
    observe(1'b0, 1'b0, 400);
    n_tests++;
    if (s_timeout) begin n_fail++; $display("FAIL press_timeout got=no_done want=done"); end
    n_tests++;
    if (s_press_rises != 3) begin n_fail++; $display("FAIL press_rises got=%0d want=3", s_press_rises); end
    n_tests++;
    if (s_rel_rises != 2) begin n_fail++; $display("FAIL release_rises got=%0d want=2", s_rel_rises); end
    n_tests++;
    if (s_hold_cyc != 20 || s_hold_low != 0) begin
      n_fail++; $display("FAIL hold_len got=%0d/%0d low want=20/0", s_hold_cyc, s_hold_low);
    end
    n_tests++;
    if (s_settle_run != 10) begin n_fail++; $display("FAIL settle_len got=%0d want=10", s_settle_run); end
    n_tests++;
    if (s_busy_low != 0 || s_done_busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_span got=%0d low,%b at done want=0,0", s_busy_low, s_done_busy);
    end
    tick();
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_width got=%b want=0", done); end
  endtask

  task automatic test_ignore_busy();
    int extra_done, extra_busy;
    press_req = 1'b1;
    tick();
    press_req = 1'b0;
    observe(1'b0, 1'b1, 400);
    n_tests++;
    if (s_done != 1 || s_timeout) begin n_fail++; $display("FAIL ignore_done got=%0d want=1", s_done); end
    n_tests++;
    if (s_hold_cyc != 20) begin n_fail++; $display("FAIL ignore_hold got=%0d want=20", s_hold_cyc); end
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    n_tests++;
    if (extra_done != 0 || extra_busy != 0) begin
      n_fail++; $display("FAIL ignore_queue got=%0d done,%0d busy want=0,0", extra_done, extra_busy);
    end
  endtask

  task automatic test_clean_edges();
    press0 = 1'b1;
    tick();
    press0 = 1'b0;
    n_tests++;
    if (busy0 !== 1'b1 || btn0 !== 1'b0) begin
      n_fail++; $display("FAIL clean_start got=%b%b want=10", busy0, btn0);
    end
    observe(1'b1, 1'b0, 400);
    n_tests++;
    if (s_timeout || s_done != 1) begin n_fail++; $display("FAIL clean_done got=%0d want=1", s_done); end
    n_tests++;
    if (s_press_rises + s_rel_rises != 1 || s_falls != 1) begin
      n_fail++;
      $display("FAIL clean_edges got=%0d rises,%0d falls want=1,1", s_press_rises + s_rel_rises, s_falls);
    end
    n_tests++;
    if (s_hold_cyc != 20 || s_hold_low != 0) begin
      n_fail++; $display("FAIL clean_hold got=%0d/%0d want=20/0", s_hold_cyc, s_hold_low);
    end
    // High run is HOLD plus the one release gap of 1..4 cycles
    n_tests++;
    if (s_max_high < 21 || s_max_high > 24) begin
      n_fail++; $display("FAIL clean_high got=%0d want=21..24", s_max_high);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int n_done;
    press_req = 1'b1;
    tick();
    press_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dut.state_q == ST_REL_B) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL mid_reach got=no_rel_b want=rel_b"); end
    rst_n = 1'b0;
    tick();
    n_tests++;
    if ({btn_out, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL mid_reset got=%b want=000", {btn_out, busy, done});
    end
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    n_tests++;
    if (n_done != 0) begin n_fail++; $display("FAIL mid_no_done got=%0d want=0", n_done); end
    press_req = 1'b1;
    tick();
    press_req = 1'b0;
    observe(1'b0, 1'b0, 400);
    n_tests++;
    if (s_timeout || s_press_rises != 3 || s_rel_rises != 2 || s_hold_cyc != 20) begin
      n_fail++;
      $display("FAIL mid_rerun got=%0d/%0d/%0d want=3/2/20", s_press_rises, s_rel_rises, s_hold_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int rises, n_done, n_busy;
    bit prev;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    prev = btn_out;
    rises = 0; n_done = 0;
    press_req = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (btn_out && !prev) rises++;
      prev = btn_out;
      if (done) n_done++;
      if (n_done == 1 && busy) press_req = 1'b0;
      if (n_done == 2) break;
    end
    press_req = 1'b0;
    n_tests++;
    if (n_done != 2) begin n_fail++; $display("FAIL b2b_done got=%0d want=2", n_done); end
    n_tests++;
    if (rises != 10) begin n_fail++; $display("FAIL b2b_rises got=%0d want=10", rises); end
    n_busy = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) n_busy++;
    end
    n_tests++;
    if (n_busy != 0) begin n_fail++; $display("FAIL b2b_third got=%0d busy want=0", n_busy); end
`ifdef BOUNCE_GEN_RISE_CNT_EN
    n_tests++;
    if (rise_count !== 8'd10) begin n_fail++; $display("FAIL b2b_rise_count got=%0d want=10", rise_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_press();
    test_ignore_busy();
    test_clean_edges();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
